// File: rtl/p2s_transmitter.sv
// Parallel-to-serial transmitter: shifts words out MSB first with a generated serial clock,
// a one-deep holding register for the next word, and an idle gap after every word.
module p2s_transmitter #(
  parameter int DATA_W   = 8,
  parameter int HALF_PER = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic              iclk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sclk_out,
  output logic              serial_out,
  output logic              busy,
  output logic              word_done
);

  localparam int HW = $clog2(HALF_PER) + 1;
  localparam int BW = $clog2(DATA_W);
  localparam int GW = $clog2(GAP_CYC) + 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PER - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} state_t;

  state_t            state,      state_nx;
  logic [DATA_W-1:0] hold,       hold_nx;
  logic              hold_valid, hold_valid_nx;
  logic [DATA_W-1:0] shreg,      shreg_nx;
  logic [BW-1:0]     bit_cnt,    bit_cnt_nx;
  logic [HW-1:0]     half_cnt,   half_cnt_nx;
  logic [GW-1:0]     gap_cnt,    gap_cnt_nx;
  logic              sclk_nx, serial_nx, done_nx;

  assign tx_ready = !hold_valid;
  assign busy     = (state != IDLE) || hold_valid;

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      half_cnt   <= '0;
      gap_cnt    <= '0;
      sclk_out   <= 1'b0;
      serial_out <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      hold       <= hold_nx;
      hold_valid <= hold_valid_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      half_cnt   <= half_cnt_nx;
      gap_cnt    <= gap_cnt_nx;
      sclk_out   <= sclk_nx;
      serial_out <= serial_nx;
      word_done  <= done_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    hold_nx       = hold;
    hold_valid_nx = hold_valid;
    shreg_nx      = shreg;
    bit_cnt_nx    = bit_cnt;
    half_cnt_nx   = half_cnt;
    gap_cnt_nx    = gap_cnt;
    done_nx       = 1'b0;

    case (state)
      IDLE: begin
        if (hold_valid) begin
          shreg_nx      = hold;
          hold_valid_nx = 1'b0;
          bit_cnt_nx    = '0;
          half_cnt_nx   = '0;
          state_nx      = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (half_cnt == HALF_LAST) begin
          half_cnt_nx = '0;
          state_nx    = SHIFT_HI;
        end else begin
          half_cnt_nx = half_cnt + HW'(1);
        end
      end
      SHIFT_HI: begin
        if (half_cnt == HALF_LAST) begin
          half_cnt_nx = '0;
          if (bit_cnt == BIT_LAST) begin
            done_nx    = 1'b1;
            gap_cnt_nx = '0;
            state_nx   = GAP;
          end else begin
            shreg_nx   = {shreg[DATA_W-2:0], 1'b0};
            bit_cnt_nx = bit_cnt + BW'(1);
            state_nx   = SHIFT_LO;
          end
        end else begin
          half_cnt_nx = half_cnt + HW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nx = '0;
          state_nx   = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Accept only while hold is empty; the IDLE drain above never coincides with this
    if (tx_valid && !hold_valid) begin
      hold_nx       = tx_data;
      hold_valid_nx = 1'b1;
    end

    // Outputs are registered from the next state so the MSB appears right after the load edge
    sclk_nx   = (state_nx == SHIFT_HI);
    serial_nx = ((state_nx == SHIFT_LO) || (state_nx == SHIFT_HI)) ? shreg_nx[DATA_W-1] : 1'b0;
  end

endmodule

// File: tb/tb_p2s_transmitter.sv
// Bench for p2s_transmitter: two instances (default and 16/1/1 parameters) checked every cycle
// against a word-timeline model, with directed scenarios and randomized traffic.
module tb_p2s_transmitter;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] tv   = '0;
  logic [7:0] td0  = '0;
  logic [15:0] td1 = '0;
  logic [1:0] rdy, sclk, sout, bsy, done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  p2s_transmitter #(.DATA_W(8), .HALF_PER(2), .GAP_CYC(4)) dut0 (
    .iclk(clk), .rstn(rstn), .tx_data(td0), .tx_valid(tv[0]), .tx_ready(rdy[0]),
    .sclk_out(sclk[0]), .serial_out(sout[0]), .busy(bsy[0]), .word_done(done[0])
  );

  p2s_transmitter #(.DATA_W(16), .HALF_PER(1), .GAP_CYC(1)) dut1 (
    .iclk(clk), .rstn(rstn), .tx_data(td1), .tx_valid(tv[1]), .tx_ready(rdy[1]),
    .sclk_out(sclk[1]), .serial_out(sout[1]), .busy(bsy[1]), .word_done(done[1])
  );

  always #5 clk = ~clk;

  function automatic int pd(input int i); return (i == 0) ? 8 : 16; endfunction
  function automatic int ph(input int i); return (i == 0) ? 2 : 1;  endfunction
  function automatic int pg(input int i); return (i == 0) ? 4 : 1;  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each loaded word follows a fixed timeline k = cycles since its load edge
  bit          m_act[2] = '{0, 0};
  int          m_k[2]   = '{0, 0};
  bit          m_hv[2]  = '{0, 0};
  logic [15:0] m_word[2];
  logic [15:0] m_hold[2];
  logic [15:0] expq0[$];
  logic [15:0] expq1[$];
  int          acc_cyc[2]  = '{0, 0};
  int          done_cyc[2] = '{0, 0};

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int i = 0; i < 2; i++) begin
          m_act[i] = 0; m_k[i] = 0; m_hv[i] = 0;
        end
        expq0.delete();
        expq1.delete();
      end else begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
          bit acc;
          logic [15:0] din;
          acc = tv[i] && !m_hv[i];
          din = (i == 0) ? {8'h00, td0} : td1;
          if (m_act[i] && m_k[i] < 2 * pd(i) * ph(i) + pg(i)) begin
            m_k[i]++;
          end else if (m_hv[i]) begin
            m_word[i] = m_hold[i];
            m_hv[i]   = 0;
            m_act[i]  = 1;
            m_k[i]    = 0;
            if (i == 0) expq0.push_back(m_word[i]);
            else        expq1.push_back(m_word[i]);
          end else begin
            m_act[i] = 0;
          end
          if (acc) begin
            m_hold[i]  = din;
            m_hv[i]    = 1;
            acc_cyc[i] = cyc;
          end
        end
      end
    end
  end

  // Per-cycle compare plus a receiver that shifts serial_out on each sclk_out rise
  bit          prev_sclk[2]  = '{0, 0};
  int          rise_total[2] = '{0, 0};
  int          wrises[2]     = '{0, 0};
  logic [15:0] rx[2]         = '{16'h0, 16'h0};
  int          riseq0[$];
  logic [15:0] rxlog0[$];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int D, H, G, k;
        logic e_sclk, e_sout, e_done, e_busy, e_rdy, shifting;
        logic [15:0] w, mask;
        D = pd(i); H = ph(i); G = pg(i); k = m_k[i];
        shifting = m_act[i] && (k < 2 * D * H);
        e_sclk   = shifting && ((k % (2 * H)) >= H);
        e_sout   = 1'b0;
        if (shifting) e_sout = m_word[i][D - 1 - k / (2 * H)];
        e_done   = m_act[i] && (k == 2 * D * H);
        e_busy   = (m_act[i] && (k < 2 * D * H + G)) || m_hv[i];
        e_rdy    = !m_hv[i];
        chk($sformatf("sclk_out[%0d]", i),   32'(sclk[i]), 32'(e_sclk));
        chk($sformatf("serial_out[%0d]", i), 32'(sout[i]), 32'(e_sout));
        chk($sformatf("word_done[%0d]", i),  32'(done[i]), 32'(e_done));
        chk($sformatf("busy[%0d]", i),       32'(bsy[i]),  32'(e_busy));
        chk($sformatf("tx_ready[%0d]", i),   32'(rdy[i]),  32'(e_rdy));
        if (!rstn) begin
          wrises[i] = 0;
        end else begin
          if (sclk[i] && !prev_sclk[i]) begin
            rise_total[i]++;
            wrises[i]++;
            rx[i] = {rx[i][14:0], sout[i]};
            if (i == 0) riseq0.push_back(cyc);
          end
          if (done[i]) begin
            done_cyc[i] = cyc;
            chk($sformatf("rises_per_word[%0d]", i), 32'(wrises[i]), 32'(D));
            wrises[i] = 0;
            mask = (i == 0) ? 16'h00FF : 16'hFFFF;
            chk($sformatf("queue_nonempty[%0d]", i),
                32'((i == 0) ? expq0.size() : expq1.size()) != 0 ? 32'd1 : 32'd0, 32'd1);
            if (i == 0 && expq0.size() != 0) begin
              w = expq0.pop_front();
              chk("decoded_word[0]", 32'(rx[0] & mask), 32'(w));
              rxlog0.push_back(rx[0] & mask);
            end else if (i == 1 && expq1.size() != 0) begin
              w = expq1.pop_front();
              chk("decoded_word[1]", 32'(rx[1] & mask), 32'(w));
            end
          end
        end
        prev_sclk[i] = sclk[i];
      end
    end
  end

  task automatic send(input int i, input logic [15:0] d);
    int n = 0;
    while (!rdy[i] && n < 200) begin @(negedge clk); n++; end
    chk($sformatf("send_ready_timeout[%0d]", i), 32'(rdy[i]), 32'd1);
    if (i == 0) td0 = d[7:0];
    else        td1 = d;
    tv[i] = 1'b1;
    @(negedge clk);
    tv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (bsy[i] && n < 300) begin @(negedge clk); n++; end
    chk($sformatf("idle_timeout[%0d]", i), 32'(bsy[i]), 32'd0);
  endtask

  initial begin
    int base, n;
    // 1: reset with valid asserted
    tv = 2'b11; td0 = 8'h5A; td1 = 16'h1234;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t1_sclk",  32'(sclk[i]), 32'd0);
      chk("t1_sout",  32'(sout[i]), 32'd0);
      chk("t1_ready", 32'(rdy[i]),  32'd1);
      chk("t1_busy",  32'(bsy[i]),  32'd0);
      chk("t1_done",  32'(done[i]), 32'd0);
    end
    tv = 2'b00;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_nothing_sent", 32'(rise_total[0] + rise_total[1]), 32'd0);

    // 2: single word A5
    base = rise_total[0];
    rxlog0.delete();
    send(0, 16'h00A5);
    wait_idle(0);
    chk("t2_rises",        32'(rise_total[0] - base), 32'd8);
    chk("t2_bits",         32'(rx[0][7:0]), 32'h0A5);
    chk("t2_done_latency", 32'(done_cyc[0] - (acc_cyc[0] + 1)), 32'd32);
    chk("t2_log_size",     32'(rxlog0.size()), 32'd1);

    // 3: 3C then C3 with valid held high
    rxlog0.delete();
    riseq0.delete();
    td0 = 8'h3C; tv[0] = 1'b1;
    @(negedge clk);
    chk("t3_ready_fall", 32'(rdy[0]), 32'd0);
    td0 = 8'hC3;
    @(negedge clk);
    chk("t3_ready_rise", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    chk("t3_c3_accepted", 32'(rdy[0]), 32'd0);
    tv[0] = 1'b0;
    wait_idle(0);
    chk("t3_log_size", 32'(rxlog0.size()), 32'd2);
    if (rxlog0.size() == 2) begin
      chk("t3_word0", 32'(rxlog0[0]), 32'h3C);
      chk("t3_word1", 32'(rxlog0[1]), 32'hC3);
    end
    chk("t3_rise_count", 32'(riseq0.size()), 32'd16);
    if (riseq0.size() == 16) chk("t3_spacing", 32'(riseq0[8] - riseq0[0]), 32'd37);

    // 4: held word is not overwritten
    rxlog0.delete();
    send(0, 16'h00AA);
    send(0, 16'h0055);
    td0 = 8'h11; tv[0] = 1'b1;
    chk("t4_ready_low", 32'(rdy[0]), 32'd0);
    n = 0;
    while (!rdy[0] && n < 200) begin @(negedge clk); n++; end
    chk("t4_ready_timeout", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    tv[0] = 1'b0;
    wait_idle(0);
    chk("t4_log_size", 32'(rxlog0.size()), 32'd3);
    if (rxlog0.size() == 3) begin
      chk("t4_word0", 32'(rxlog0[0]), 32'hAA);
      chk("t4_word1", 32'(rxlog0[1]), 32'h55);
      chk("t4_word2", 32'(rxlog0[2]), 32'h11);
    end

    // 5: reset mid-word discards current and held words
    rxlog0.delete();
    base = rise_total[0];
    send(0, 16'h000F);
    send(0, 16'h00F0);
    n = 0;
    while (rise_total[0] < base + 3 && n < 200) begin @(negedge clk); n++; end
    chk("t5_three_rises", 32'(rise_total[0] - base), 32'd3);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t5_sclk",  32'(sclk[0]), 32'd0);
    chk("t5_sout",  32'(sout[0]), 32'd0);
    chk("t5_busy",  32'(bsy[0]),  32'd0);
    chk("t5_ready", 32'(rdy[0]),  32'd1);
    chk("t5_done",  32'(done[0]), 32'd0);
    base = rise_total[0];
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_no_edges", 32'(rise_total[0] - base), 32'd0);
    chk("t5_no_words", 32'(rxlog0.size()), 32'd0);
    send(0, 16'h00FF);
    wait_idle(0);
    chk("t5_ff_rises", 32'(rise_total[0] - base), 32'd8);
    chk("t5_ff_size",  32'(rxlog0.size()), 32'd1);
    if (rxlog0.size() == 1) chk("t5_ff_word", 32'(rxlog0[0]), 32'hFF);

    // 6: 16-bit instance, HALF_PER=1, GAP_CYC=1
    base = rise_total[1];
    send(1, 16'h8001);
    wait_idle(1);
    chk("t6_rises",        32'(rise_total[1] - base), 32'd16);
    chk("t6_bits",         32'(rx[1]), 32'h8001);
    chk("t6_done_latency", 32'(done_cyc[1] - (acc_cyc[1] + 1)), 32'd32);

    // Randomized traffic on both instances with one reset pulse mid-run
    for (int r = 0; r < 3000; r++) begin
      tv[0] = ($urandom_range(0, 2) == 0);
      tv[1] = ($urandom_range(0, 2) == 0);
      td0   = 8'($urandom);
      td1   = 16'($urandom);
      if (r == 1500) begin
        @(posedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
      @(negedge clk);
    end
    tv = 2'b00;
    wait_idle(0);
    wait_idle(1);
    chk("rand_drained0", 32'(expq0.size()), 32'd0);
    chk("rand_drained1", 32'(expq1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
